// File: rtl/joypad_port_if.sv
// Host-side CPU bus bundle for the $4016/$4017 controller-port responder.
interface joypad_port_if;
  logic       I_host_select;
  logic       I_host_addr;
  logic       I_host_wren;
  logic       I_host_rden;
  logic [7:0] I_host_data;
  logic [7:0] O_host_data;

  modport master (
    output I_host_select, I_host_addr, I_host_wren, I_host_rden, I_host_data,
    input  O_host_data
  );

  modport slave (
    input  I_host_select, I_host_addr, I_host_wren, I_host_rden, I_host_data,
    output O_host_data
  );
endinterface

// File: rtl/joypad_port.sv
// Two-pad NES controller port: background serial pad scanner plus the
// console-style strobe/shift-on-read host interface at $4016/$4017.
module joypad_port #(
  parameter int unsigned P_clock_div = 6,
  parameter int unsigned P_scan_gap  = 16384
) (
  input  logic         I_clock,
  input  logic         I_reset,
  joypad_port_if.slave host,
  output logic         O_pad_latch,
  output logic         O_pad_clock,
  input  logic [1:0]   I_pad_data
);
  localparam int unsigned CNT_MAX = (P_scan_gap > 2 * P_clock_div) ? P_scan_gap : 2 * P_clock_div;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(P_scan_gap - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * P_clock_div - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(P_clock_div - 1);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_COMMIT} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic            latch_q, pclk_q;
  logic [1:0][7:0] asm_q, snap_q;

  logic [1:0][7:0] shift_q, shift_d;
  logic            strobe_q, strobe_d;
  logic            rd_q, rd_addr_q;
  logic            rd_now, rd_fall;

  assign O_pad_latch = latch_q;
  assign O_pad_clock = pclk_q;

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      asm_q   <= '0;
      snap_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            latch_q <= 1'b1;
            state_q <= S_LATCH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_LATCH: begin
          if (cnt_q == LATCH_LAST) begin
            cnt_q   <= '0;
            latch_q <= 1'b0;
            bit_q   <= '0;
            state_q <= S_LOW;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_LOW: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q           <= '0;
            // Pads are active-low; store 1 = pressed.
            asm_q[0][bit_q] <= ~I_pad_data[0];
            asm_q[1][bit_q] <= ~I_pad_data[1];
            if (bit_q == 3'd7) begin
              state_q <= S_COMMIT;
            end else begin
              pclk_q  <= 1'b1;
              state_q <= S_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            pclk_q  <= 1'b0;
            bit_q   <= bit_q + 3'd1;
            state_q <= S_LOW;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_COMMIT: begin
          snap_q  <= asm_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_now  = host.I_host_select & host.I_host_rden;
  assign rd_fall = rd_q & ~rd_now;

  // Reload while strobed has priority over the end-of-read shift; a strobe
  // write only takes effect from the following cycle.
  always_comb begin
    strobe_d = strobe_q;
    if (host.I_host_select && host.I_host_wren && !host.I_host_addr)
      strobe_d = host.I_host_data[0];
    shift_d = shift_q;
    if (strobe_q)
      shift_d = snap_q;
    else if (rd_fall)
      shift_d[rd_addr_q] = {1'b1, shift_q[rd_addr_q][7:1]};
  end

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      strobe_q  <= 1'b0;
      shift_q   <= '0;
      rd_q      <= 1'b0;
      rd_addr_q <= 1'b0;
    end else begin
      strobe_q  <= strobe_d;
      shift_q   <= shift_d;
      rd_q      <= rd_now;
      rd_addr_q <= host.I_host_addr;
    end
  end

  assign host.O_host_data = {7'b0100000, shift_q[host.I_host_addr][0]};
endmodule

// File: tb/tb_joypad_port.sv
// Self-checking bench for joypad_port: behavioural pads plus a per-port
// read-index model of the console strobe/shift protocol.
module tb_joypad_port;
  localparam int DIV = 6;
  localparam int GAP = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic latch, pclk;
  logic [1:0] pad_data;
  logic [1:0][7:0] btn = '1;
  logic [1:0][7:0] pad_sr = '1;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  joypad_port_if bus();

  joypad_port #(.P_clock_div(DIV), .P_scan_gap(GAP)) dut (
    .I_clock    (clk),
    .I_reset    (rst),
    .host       (bus.slave),
    .O_pad_latch(latch),
    .O_pad_clock(pclk),
    .I_pad_data (pad_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4021-style pad: parallel load on latch, shift toward bit0 on clock rise.
  always @(posedge latch or posedge pclk) begin
    if (latch) pad_sr <= btn;
    else begin
      pad_sr[0] <= {1'b1, pad_sr[0][7:1]};
      pad_sr[1] <= {1'b1, pad_sr[1][7:1]};
    end
  end
  assign pad_data = {pad_sr[1][0], pad_sr[0][0]};

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [7:0] exp_read(input logic [7:0] pressed, input int n);
    logic b;
    b = (n < 8) ? pressed[n[2:0]] : 1'b1;
    return {7'b0100000, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic a, input logic [7:0] d);
    bus.I_host_select = 1'b1; bus.I_host_wren = 1'b1;
    bus.I_host_addr = a; bus.I_host_data = d;
    tick();
    bus.I_host_select = 1'b0; bus.I_host_wren = 1'b0;
  endtask

  task automatic strobe_pulse();
    host_write(1'b0, 8'h01);
    host_write(1'b0, 8'h00);
  endtask

  task automatic host_read(input logic a, input int width,
                           output logic [7:0] d_first, output logic [7:0] d_last);
    bus.I_host_select = 1'b1; bus.I_host_rden = 1'b1; bus.I_host_addr = a;
    #1 d_first = bus.O_host_data;
    repeat (width - 1) tick();
    d_last = bus.O_host_data;
    tick();
    bus.I_host_select = 1'b0; bus.I_host_rden = 1'b0;
    tick();
  endtask

  task automatic wait_scan();
    bit prev, rose;
    int n;
    prev = latch; rose = 0; n = 0;
    while (!rose && n < 2 * (GAP + 20 * DIV)) begin
      tick(); n++;
      if (latch && !prev) rose = 1;
      prev = latch;
    end
    n = 0;
    while (rose && latch && n < 4 * DIV) begin tick(); n++; end
    total++;
    if (!rose || latch) begin
      $display("FAIL scan_wait got_rise=%0d latch=%0d required rise then fall", rose, latch);
      bad++;
    end
    repeat (16 * DIV) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    bus.I_host_addr = 1'b0;
    #1;
    total++; if (latch !== 1'b0) begin $display("FAIL rst_latch got=%b exp=0", latch); bad++; end
    total++; if (pclk !== 1'b0) begin $display("FAIL rst_pclk got=%b exp=0", pclk); bad++; end
    total++; if (bus.O_host_data !== 8'h40) begin $display("FAIL rst_data0 got=%h exp=40", bus.O_host_data); bad++; end
    bus.I_host_addr = 1'b1;
    #1;
    total++; if (bus.O_host_data !== 8'h40) begin $display("FAIL rst_data1 got=%h exp=40", bus.O_host_data); bad++; end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] d, dl, p;
    btn[0] = 8'b11110110; btn[1] = 8'hFF; p = ~btn[0];
    wait_scan();
    strobe_pulse();
    for (int i = 0; i < 9; i++) begin
      host_read(1'b0, 1, d, dl);
      total++;
      if (d !== exp_read(p, i)) begin $display("FAIL basic_rd%0d got=%h exp=%h", i, d, exp_read(p, i)); bad++; end
    end
  endtask

  task automatic test_strobe_held();
    logic [7:0] d, dl, p;
    p = 8'($urandom) | 8'h01;
    p[1] = 1'b0;
    btn[0] = ~p;
    wait_scan();
    host_write(1'b0, 8'h01);
    tick();
    for (int i = 0; i < 4; i++) begin
      host_read(1'b0, 1, d, dl);
      total++;
      if (d !== 8'h41) begin $display("FAIL held_rd%0d got=%h exp=41", i, d); bad++; end
    end
    host_write(1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      host_read(1'b0, 1, d, dl);
      total++;
      if (d !== exp_read(p, i)) begin $display("FAIL held_after%0d got=%h exp=%h", i, d, exp_read(p, i)); bad++; end
    end
  endtask

  task automatic test_long_rden();
    logic [7:0] d, dl, p;
    p = 8'hA5; btn[0] = ~p;
    wait_scan();
    strobe_pulse();
    for (int i = 0; i < 3; i++) begin
      host_read(1'b0, 5, d, dl);
      total++;
      if (d !== exp_read(p, i) || dl !== exp_read(p, i)) begin
        $display("FAIL long_rd%0d got=%h/%h exp=%h", i, d, dl, exp_read(p, i)); bad++;
      end
    end
    host_read(1'b0, 1, d, dl);
    total++;
    if (d !== exp_read(p, 3)) begin $display("FAIL long_next got=%h exp=%h", d, exp_read(p, 3)); bad++; end
  endtask

  task automatic test_port2();
    logic [7:0] d, dl, p1, p2;
    p1 = 8'h00; p2 = 8'h3C; btn[0] = ~p1; btn[1] = ~p2;
    wait_scan();
    strobe_pulse();
    for (int i = 0; i < 3; i++) begin
      host_read(1'b1, 1, d, dl);
      total++;
      if (d !== exp_read(p2, i)) begin $display("FAIL p2_rd%0d got=%h exp=%h", i, d, exp_read(p2, i)); bad++; end
      host_read(1'b0, 1, d, dl);
      total++;
      if (d !== exp_read(p1, i)) begin $display("FAIL p1_rd%0d got=%h exp=%h", i, d, exp_read(p1, i)); bad++; end
    end
    host_write(1'b1, 8'h01);
    tick();
    for (int i = 3; i < 9; i++) begin
      host_read(1'b1, 1, d, dl);
      total++;
      if (d !== exp_read(p2, i)) begin $display("FAIL p2_w4017_rd%0d got=%h exp=%h", i, d, exp_read(p2, i)); bad++; end
    end
    host_read(1'b0, 1, d, dl);
    total++;
    if (d !== exp_read(p1, 3)) begin $display("FAIL p1_after got=%h exp=%h", d, exp_read(p1, 3)); bad++; end
  endtask

  task automatic test_snapshot_hold();
    logic [7:0] d, dl, p_old, p_new;
    p_old = 8'($urandom);
    p_new = p_old ^ (8'($urandom) | 8'h04);
    btn[0] = ~p_old;
    wait_scan();
    strobe_pulse();
    for (int i = 0; i < 2; i++) host_read(1'b0, 1, d, dl);
    btn[0] = ~p_new;
    wait_scan();
    for (int i = 2; i < 9; i++) begin
      host_read(1'b0, 1, d, dl);
      total++;
      if (d !== exp_read(p_old, i)) begin $display("FAIL hold_old%0d got=%h exp=%h", i, d, exp_read(p_old, i)); bad++; end
    end
    strobe_pulse();
    for (int i = 0; i < 8; i++) begin
      host_read(1'b0, 1, d, dl);
      total++;
      if (d !== exp_read(p_new, i)) begin $display("FAIL hold_new%0d got=%h exp=%h", i, d, exp_read(p_new, i)); bad++; end
    end
  endtask

  task automatic test_strobe_edge();
    logic [7:0] d, dl, p;
    p = 8'($urandom) | 8'h01;
    p[1] = 1'b0;
    btn[0] = ~p;
    wait_scan();
    host_write(1'b0, 8'h01);
    bus.I_host_select = 1'b1; bus.I_host_rden = 1'b1; bus.I_host_addr = 1'b0;
    tick();
    bus.I_host_rden = 1'b0; bus.I_host_wren = 1'b1; bus.I_host_data = 8'h00;
    tick();
    bus.I_host_select = 1'b0; bus.I_host_wren = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      host_read(1'b0, 1, d, dl);
      total++;
      if (d !== exp_read(p, i)) begin $display("FAIL edge_rd%0d got=%h exp=%h", i, d, exp_read(p, i)); bad++; end
    end
  endtask

  task automatic test_random();
    logic [7:0] d, dl;
    logic [7:0] p [2];
    int n [2];
    int a, w;
    for (int it = 0; it < 3; it++) begin
      p[0] = 8'($urandom); p[1] = 8'($urandom);
      btn[0] = ~p[0]; btn[1] = ~p[1];
      wait_scan();
      strobe_pulse();
      n[0] = 0; n[1] = 0;
      for (int k = 0; k < 14; k++) begin
        a = int'($urandom_range(1, 0));
        w = int'($urandom_range(3, 1));
        host_read(a[0], w, d, dl);
        total++;
        if (d !== exp_read(p[a], n[a]) || dl !== d) begin
          $display("FAIL rand_it%0d_port%0d_rd%0d got=%h/%h exp=%h", it, a, n[a], d, dl, exp_read(p[a], n[a])); bad++;
        end
        n[a]++;
      end
    end
  endtask

  task automatic test_reset_midscan();
    logic [7:0] d, dl;
    int rises, n, t0, lw, lo, hi;
    bit prev;
    btn[0] = ~(8'($urandom) | 8'h01);
    n = 0;
    while (!latch && n < 2 * (GAP + 20 * DIV)) begin tick(); n++; end
    n = 0;
    while (latch && n < 4 * DIV) begin tick(); n++; end
    rises = 0; prev = pclk; n = 0;
    while (rises < 5 && n < 30 * DIV) begin
      tick(); n++;
      if (pclk && !prev) rises++;
      prev = pclk;
    end
    total++;
    if (rises != 5) begin $display("FAIL mid_find_high4 got=%0d exp=5", rises); bad++; end
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    total++; if (latch !== 1'b0 || pclk !== 1'b0) begin $display("FAIL mid_rst_outs got=%b%b exp=00", latch, pclk); bad++; end
    tick(); tick();
    rst = 1'b0;
    t0 = int'(cyc);
    strobe_pulse();
    for (int i = 0; i < 3; i++) begin
      host_read(1'b0, 1, d, dl);
      total++;
      if (d !== 8'h40) begin $display("FAIL mid_snap%0d got=%h exp=40", i, d); bad++; end
    end
    n = 0;
    while (!latch && n < 2 * GAP) begin tick(); n++; end
    total++;
    if (int'(cyc) - t0 != GAP) begin $display("FAIL mid_gap got=%0d exp=%0d", int'(cyc) - t0, GAP); bad++; end
    lw = 0;
    while (latch && lw < 100) begin lw++; tick(); end
    total++; if (lw != 2 * DIV) begin $display("FAIL latch_width got=%0d exp=%0d", lw, 2 * DIV); bad++; end
    lo = 0;
    while (!pclk && lo < 100) begin lo++; tick(); end
    total++; if (lo != DIV) begin $display("FAIL clk_low got=%0d exp=%0d", lo, DIV); bad++; end
    hi = 0;
    while (pclk && hi < 100) begin hi++; tick(); end
    total++; if (hi != DIV) begin $display("FAIL clk_high got=%0d exp=%0d", hi, DIV); bad++; end
  endtask

  initial begin
    bus.I_host_select = 1'b0; bus.I_host_addr = 1'b0;
    bus.I_host_wren = 1'b0; bus.I_host_rden = 1'b0; bus.I_host_data = 8'h00;
    test_reset();
    test_basic();
    test_strobe_held();
    test_long_rden();
    test_port2();
    test_snapshot_hold();
    test_strobe_edge();
    test_random();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
